// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler sharing one start/done ALU between NUM_REQ requesters.
// One operation is in flight at a time. Each operation is answered with the ALU
// result, or with an error flag when the ALU does not finish within TIMEOUT
// wait cycles.
module alu_rr_scheduler #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned OP_W    = 3,
  parameter int unsigned RES_W   = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [NUM_REQ-1:0]        rq_valid,
  output logic [NUM_REQ-1:0]        rq_ready,
  input  logic [NUM_REQ*DATA_W-1:0] rq_a,
  input  logic [NUM_REQ*DATA_W-1:0] rq_b,
  input  logic [NUM_REQ*OP_W-1:0]   rq_op,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [RES_W-1:0]          rsp_data,
  output logic                      rsp_err,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  output logic [OP_W-1:0]           alu_op,
  output logic                      alu_start,
  input  logic                      alu_done,
  input  logic [RES_W-1:0]          alu_res,
  output logic                      busy,
  output logic [15:0]               err_cnt
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [16:0] TimeoutVal = 17'(TIMEOUT);
  localparam logic [NUM_REQ-1:0] OneHot0 = NUM_REQ'(1);
  localparam logic [IdxW-1:0] LastInit = IdxW'(NUM_REQ - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     last_q, last_d;
  logic [IdxW-1:0]     gnt_q, gnt_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [RES_W-1:0]    data_q, data_d;
  logic                err_q, err_d;
  logic [15:0]         err_cnt_q, err_cnt_d;

  logic [IdxW-1:0]     arb_idx;
  logic [IdxW-1:0]     cand;
  logic                arb_any;

  // Round-robin pick: first valid requester after the one served last, with wrap.
  always_comb begin
    arb_idx = '0;
    arb_any = 1'b0;
    cand    = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = IdxW'((32'(last_q) + i) % NUM_REQ);
      if (!arb_any && rq_valid[cand]) begin
        arb_any = 1'b1;
        arb_idx = cand;
      end
    end
  end

  // Next-state logic for the FSM and its datapath registers.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    gnt_d     = gnt_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (arb_any) begin
          gnt_d   = arb_idx;
          a_d     = rq_a[arb_idx*DATA_W +: DATA_W];
          b_d     = rq_b[arb_idx*DATA_W +: DATA_W];
          op_d    = rq_op[arb_idx*OP_W +: OP_W];
          state_d = StIssue;
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        // Done is tested first so a completion on the last allowed cycle is not an error.
        if (alu_done) begin
          data_d  = alu_res;
          err_d   = 1'b0;
          state_d = StResp;
        end else if (({1'b0, cnt_q} + 17'd1) == TimeoutVal) begin
          data_d  = '0;
          err_d   = 1'b1;
          if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StResp: begin
        if (rsp_ready[gnt_q]) begin
          last_d  = gnt_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      last_q    <= LastInit;
      gnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      gnt_q     <= gnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Handshake and status outputs decoded from the current state.
  always_comb begin
    rq_ready  = '0;
    rsp_valid = '0;
    if (state_q == StIdle && arb_any && !reset_i) rq_ready = OneHot0 << arb_idx;
    if (state_q == StResp) rsp_valid = OneHot0 << gnt_q;
    alu_start = (state_q == StIssue);
    busy      = (state_q != StIdle);
  end

  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign alu_op   = op_q;
  assign rsp_data = data_q;
  assign rsp_err  = err_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Bench for alu_rr_scheduler: a bench-side ALU model answers start pulses, and
// expected responses are queued in grant order when requests are driven.
module tb_alu_rr_scheduler;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned OW = 3;
  localparam int unsigned RW = 16;
  localparam int unsigned TO = 4;

  logic             clk;
  logic             reset;
  logic [NR-1:0]    rq_valid, rq_ready, rsp_valid, rsp_ready;
  logic [NR*DW-1:0] rq_a, rq_b;
  logic [NR*OW-1:0] rq_op;
  logic [RW-1:0]    rsp_data;
  logic             rsp_err;
  logic [DW-1:0]    alu_a, alu_b;
  logic [OW-1:0]    alu_op;
  logic             alu_start, alu_done;
  logic [RW-1:0]    alu_res;
  logic             busy;
  logic [15:0]      err_cnt;

  logic             bfm_done, man_done;
  logic [RW-1:0]    bfm_res, man_res, bfm_r;
  bit               alu_auto;
  int               alu_delay;

  assign alu_done = bfm_done | man_done;
  assign alu_res  = bfm_done ? bfm_res : man_res;

  typedef struct packed {
    logic [1:0]  idx;
    logic [15:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   viol = 0;
  bit   inflight = 0;
  int   exp_err_cnt = 0;

  // Per-cycle snapshot taken on the falling edge.
  logic [NR-1:0] cyc_acc, cyc_rsp, cyc_rspv;
  logic [RW-1:0] cyc_data;
  logic          cyc_err, cyc_start, cyc_busy;
  logic [18:0]   cyc_alu;

  alu_rr_scheduler #(
    .NUM_REQ (NR),
    .DATA_W  (DW),
    .OP_W    (OW),
    .RES_W   (RW),
    .TIMEOUT (TO)
  ) dut (
    .clk_i     (clk),
    .reset_i   (reset),
    .rq_valid  (rq_valid),
    .rq_ready  (rq_ready),
    .rq_a      (rq_a),
    .rq_b      (rq_b),
    .rq_op     (rq_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_start (alu_start),
    .alu_done  (alu_done),
    .alu_res   (alu_res),
    .busy      (busy),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] op);
    logic [15:0] r;
    case (op)
      3'd0:    r = 16'(a) * 16'(b);
      3'd1:    r = 16'(a) + 16'(b);
      3'd2:    r = 16'(a) - 16'(b);
      3'd3:    r = {8'h00, a & b};
      3'd4:    r = {8'h00, a | b};
      3'd5:    r = {8'h00, a ^ b};
      3'd6:    r = {a, b};
      default: r = {b, a};
    endcase
    return r;
  endfunction

  function automatic exp_t mk_exp(input int i, input logic [15:0] d, input logic e);
    exp_t x;
    x.idx  = 2'(i);
    x.data = d;
    x.err  = e;
    return x;
  endfunction

  function automatic logic [3:0] oh(input logic [1:0] i);
    logic [3:0] one;
    one = 4'b0001;
    return one << i;
  endfunction

  function automatic logic [2:0] idx_of(input logic [3:0] v);
    logic [2:0] r;
    r = 3'd7;
    for (int k = 3; k >= 0; k--) if (v[k]) r = 3'(k);
    return r;
  endfunction

  // ALU model: result is returned alu_delay cycles after the first WAIT cycle.
  initial begin
    bfm_done = 1'b0;
    bfm_res  = '0;
    bfm_r    = '0;
    forever begin
      @(negedge clk);
      if (alu_auto && alu_start) begin
        bfm_r = alu_fn(alu_a, alu_b, alu_op);
        @(posedge clk); #1;
        repeat (alu_delay) begin @(posedge clk); #1; end
        bfm_done = 1'b1;
        bfm_res  = bfm_r;
        @(posedge clk); #1;
        bfm_done = 1'b0;
        bfm_res  = '0;
      end
    end
  end

  task automatic drive_req(input int i, input logic [7:0] a, input logic [7:0] b,
                           input logic [2:0] op);
    rq_valid[i]          = 1'b1;
    rq_a[i*DW +: DW]     = a;
    rq_b[i*DW +: DW]     = b;
    rq_op[i*OW +: OW]    = op;
  endtask

  // Advance one clock: sample on the falling edge, then retire accepted requests.
  task automatic cycle();
    @(negedge clk);
    cyc_acc   = rq_valid & rq_ready;
    cyc_rsp   = rsp_valid & rsp_ready;
    cyc_rspv  = rsp_valid;
    cyc_data  = rsp_data;
    cyc_err   = rsp_err;
    cyc_start = alu_start;
    cyc_busy  = busy;
    cyc_alu   = {alu_a, alu_b, alu_op};
    if (rq_ready != '0 && inflight) viol++;
    if (!$onehot0(rq_ready)) viol++;
    if ((rq_ready & ~rq_valid) != '0) viol++;
    if (cyc_rsp != '0) inflight = 1'b0;
    if (cyc_acc != '0) inflight = 1'b1;
    @(posedge clk); #1;
    rq_valid = rq_valid & ~cyc_acc;
  endtask

  task automatic run_until_rsp(input int max, output int n, output bit ok);
    ok = 1'b0;
    n  = 0;
    while (!ok && n < max) begin
      cycle();
      n++;
      if (cyc_rsp != '0) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cycle();
    cycle();
    checks++;
    if ({rq_ready, rsp_valid, rsp_data, rsp_err, alu_a, alu_b, alu_op, alu_start, busy,
         err_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_hold: outputs not zero (rsp_valid=%b data=%h busy=%b err_cnt=%0d)",
               rsp_valid, rsp_data, busy, err_cnt);
    end
    reset = 1'b0;
    cycle();
    checks++;
    if ({cyc_rspv, cyc_start, cyc_busy, cyc_alu, cyc_data, cyc_err, err_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_release: outputs not zero (rsp_valid=%b busy=%b alu=%h)",
               cyc_rspv, cyc_busy, cyc_alu);
    end
  endtask

  task automatic test_single();
    exp_t e;
    drive_req(0, 8'h05, 8'h03, 3'd1);
    sb.push_back(mk_exp(0, alu_fn(8'h05, 8'h03, 3'd1), 1'b0));
    cycle();
    checks++;
    if (cyc_acc !== 4'b0001) begin
      errors++;
      $display("FAIL single_accept: got %b expected 0001", cyc_acc);
    end
    cycle();
    checks++;
    if (cyc_start !== 1'b1 || cyc_alu !== {8'h05, 8'h03, 3'd1}) begin
      errors++;
      $display("FAIL single_issue: start=%b alu=%h expected start=1 alu=%h",
               cyc_start, cyc_alu, {8'h05, 8'h03, 3'd1});
    end
    cycle();
    checks++;
    if (cyc_start !== 1'b0 || cyc_rspv !== 4'b0000) begin
      errors++;
      $display("FAIL single_wait: start=%b rsp_valid=%b expected 0 and 0000",
               cyc_start, cyc_rspv);
    end
    cycle();
    checks++;
    e = sb.pop_front();
    if (cyc_rsp !== oh(e.idx) || cyc_data !== e.data || cyc_err !== e.err) begin
      errors++;
      $display("FAIL single_resp: rsp=%b data=%h err=%b expected %b %h %b",
               cyc_rsp, cyc_data, cyc_err, oh(e.idx), e.data, e.err);
    end
    cycle();
    checks++;
    if (cyc_busy !== 1'b0 || cyc_rspv !== 4'b0000) begin
      errors++;
      $display("FAIL single_idle: busy=%b rsp_valid=%b expected 0 0000", cyc_busy, cyc_rspv);
    end
  endtask

  task automatic test_round_robin();
    exp_t        e;
    logic [2:0]  grants [0:7];
    logic [14:0] got_g, exp_g;
    int          n_gr, got;
    bit          reloaded;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    inflight = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_req(i, 8'(8'h11 * (i + 1)), 8'(8'h07 + i), 3'(i + 4));
      sb.push_back(mk_exp(i, alu_fn(8'(8'h11 * (i + 1)), 8'(8'h07 + i), 3'(i + 4)), 1'b0));
    end
    n_gr = 0;
    got = 0;
    reloaded = 1'b0;
    for (int c = 0; c < 80 && got < 5; c++) begin
      cycle();
      if (cyc_acc != '0) begin
        if (n_gr < 8) grants[n_gr] = idx_of(cyc_acc);
        n_gr++;
        if (cyc_acc[0] && !reloaded) begin
          reloaded = 1'b1;
          drive_req(0, 8'hC3, 8'h5A, 3'd2);
          sb.push_back(mk_exp(0, alu_fn(8'hC3, 8'h5A, 3'd2), 1'b0));
        end
      end
      if (cyc_rsp != '0) begin
        got++;
        checks++;
        e = sb.pop_front();
        if (cyc_rsp !== oh(e.idx) || cyc_data !== e.data || cyc_err !== e.err) begin
          errors++;
          $display("FAIL rr_resp%0d: rsp=%b data=%h err=%b expected %b %h %b",
                   got, cyc_rsp, cyc_data, cyc_err, oh(e.idx), e.data, e.err);
        end
      end
    end
    checks++;
    if (got != 5 || n_gr != 5) begin
      errors++;
      $display("FAIL rr_count: responses=%0d grants=%0d expected 5 and 5", got, n_gr);
    end else begin
      got_g = {grants[0], grants[1], grants[2], grants[3], grants[4]};
      exp_g = {3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
      checks++;
      if (got_g !== exp_g) begin
        errors++;
        $display("FAIL rr_order: grants=%h expected %h", got_g, exp_g);
      end
    end
    checks++;
    if (viol != 0) begin
      errors++;
      $display("FAIL rr_ready_outside_idle: violations=%0d expected 0", viol);
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    int   n;
    bit   ok, noisy;
    alu_auto = 1'b0;
    drive_req(1, 8'h33, 8'h44, 3'd3);
    sb.push_back(mk_exp(1, 16'h0000, 1'b1));
    exp_err_cnt++;
    cycle();
    checks++;
    if (cyc_acc !== 4'b0010) begin
      errors++;
      $display("FAIL to_accept: got %b expected 0010", cyc_acc);
    end
    run_until_rsp(20, n, ok);
    checks++;
    if (!ok || n != 6) begin
      errors++;
      $display("FAIL to_latency: ok=%0d cycles=%0d expected 1 and 6", ok, n);
    end
    if (ok) begin
      checks++;
      e = sb.pop_front();
      if (cyc_rsp !== oh(e.idx) || cyc_data !== e.data || cyc_err !== e.err) begin
        errors++;
        $display("FAIL to_resp: rsp=%b data=%h err=%b expected %b %h %b",
                 cyc_rsp, cyc_data, cyc_err, oh(e.idx), e.data, e.err);
      end
    end
    checks++;
    if (err_cnt !== 16'(exp_err_cnt)) begin
      errors++;
      $display("FAIL to_err_cnt: got %0d expected %0d", err_cnt, exp_err_cnt);
    end
    man_res  = 16'hBEEF;
    man_done = 1'b1;
    cycle();
    man_done = 1'b0;
    noisy = (cyc_rspv != '0) || cyc_busy;
    repeat (3) begin
      cycle();
      if (cyc_rspv != '0 || cyc_busy) noisy = 1'b1;
    end
    checks++;
    if (noisy || err_cnt !== 16'(exp_err_cnt)) begin
      errors++;
      $display("FAIL to_late_done: activity=%0d err_cnt=%0d expected 0 and %0d",
               noisy, err_cnt, exp_err_cnt);
    end
    alu_auto = 1'b1;
  endtask

  task automatic test_backpressure();
    exp_t e;
    int   n, stable;
    bit   ok;
    rsp_ready = 4'b1011;
    drive_req(2, 8'h9C, 8'h27, 3'd0);
    sb.push_back(mk_exp(2, alu_fn(8'h9C, 8'h27, 3'd0), 1'b0));
    cycle();
    checks++;
    if (cyc_acc !== 4'b0100) begin
      errors++;
      $display("FAIL bp_accept: got %b expected 0100", cyc_acc);
    end
    drive_req(3, 8'h0F, 8'hF0, 3'd4);
    sb.push_back(mk_exp(3, alu_fn(8'h0F, 8'hF0, 3'd4), 1'b0));
    n = 0;
    while (cyc_rspv == '0 && n < 10) begin
      cycle();
      n++;
    end
    e = sb[0];
    stable = 0;
    for (int c = 0; c < 10; c++) begin
      cycle();
      if (cyc_rspv === 4'b0100 && cyc_data === e.data && cyc_err === 1'b0 && cyc_acc === '0)
        stable++;
    end
    checks++;
    if (stable != 10) begin
      errors++;
      $display("FAIL bp_hold: stable cycles=%0d expected 10 (data %h)", stable, e.data);
    end
    rsp_ready = 4'b1111;
    cycle();
    checks++;
    e = sb.pop_front();
    if (cyc_rsp !== oh(e.idx) || cyc_data !== e.data || cyc_err !== e.err ||
        cyc_acc !== 4'b0000) begin
      errors++;
      $display("FAIL bp_handshake: rsp=%b data=%h acc=%b expected %b %h 0000",
               cyc_rsp, cyc_data, cyc_acc, oh(e.idx), e.data);
    end
    cycle();
    checks++;
    if (cyc_acc !== 4'b1000) begin
      errors++;
      $display("FAIL bp_next_accept: got %b expected 1000", cyc_acc);
    end
    run_until_rsp(20, n, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bp_second: no response within 20 cycles");
    end else begin
      e = sb.pop_front();
      if (cyc_rsp !== oh(e.idx) || cyc_data !== e.data || cyc_err !== e.err) begin
        errors++;
        $display("FAIL bp_second: rsp=%b data=%h err=%b expected %b %h %b",
                 cyc_rsp, cyc_data, cyc_err, oh(e.idx), e.data, e.err);
      end
    end
  endtask

  task automatic test_timeout_boundary();
    exp_t e;
    int   n;
    bit   ok;
    // Done on the last allowed WAIT cycle wins over the timeout.
    alu_delay = 3;
    drive_req(0, 8'h7E, 8'h81, 3'd6);
    sb.push_back(mk_exp(0, alu_fn(8'h7E, 8'h81, 3'd6), 1'b0));
    run_until_rsp(20, n, ok);
    checks++;
    if (!ok || n != 7) begin
      errors++;
      $display("FAIL edge_done_latency: ok=%0d cycles=%0d expected 1 and 7", ok, n);
    end
    if (ok) begin
      checks++;
      e = sb.pop_front();
      if (cyc_rsp !== oh(e.idx) || cyc_data !== e.data || cyc_err !== e.err ||
          err_cnt !== 16'(exp_err_cnt)) begin
        errors++;
        $display("FAIL edge_done: rsp=%b data=%h err=%b cnt=%0d expected %b %h %b %0d",
                 cyc_rsp, cyc_data, cyc_err, err_cnt, oh(e.idx), e.data, e.err, exp_err_cnt);
      end
    end
    // One cycle later the timeout fires first.
    alu_delay = 4;
    drive_req(1, 8'h12, 8'h34, 3'd1);
    sb.push_back(mk_exp(1, 16'h0000, 1'b1));
    exp_err_cnt++;
    run_until_rsp(20, n, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL edge_late: no response within 20 cycles");
    end else begin
      e = sb.pop_front();
      if (cyc_rsp !== oh(e.idx) || cyc_data !== e.data || cyc_err !== e.err ||
          err_cnt !== 16'(exp_err_cnt)) begin
        errors++;
        $display("FAIL edge_late: rsp=%b data=%h err=%b cnt=%0d expected %b %h %b %0d",
                 cyc_rsp, cyc_data, cyc_err, err_cnt, oh(e.idx), e.data, e.err, exp_err_cnt);
      end
    end
    cycle();
    alu_delay = 0;
  endtask

  task automatic test_reset_in_wait();
    exp_t       e;
    int         n, got;
    bit         ok, noisy;
    logic [2:0] first_g;
    drive_req(2, 8'h21, 8'h12, 3'd5);
    sb.push_back(mk_exp(2, alu_fn(8'h21, 8'h12, 3'd5), 1'b0));
    run_until_rsp(20, n, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rw_pre: no response within 20 cycles");
    end else begin
      e = sb.pop_front();
      if (cyc_rsp !== oh(e.idx) || cyc_data !== e.data || cyc_err !== e.err) begin
        errors++;
        $display("FAIL rw_pre: rsp=%b data=%h expected %b %h",
                 cyc_rsp, cyc_data, oh(e.idx), e.data);
      end
    end
    // Abandoned operation: no expectation is queued for it.
    alu_auto = 1'b0;
    drive_req(3, 8'hA0, 8'h0B, 3'd6);
    cycle();
    checks++;
    if (cyc_acc !== 4'b1000) begin
      errors++;
      $display("FAIL rw_accept: got %b expected 1000", cyc_acc);
    end
    cycle();
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    inflight = 1'b0;
    exp_err_cnt = 0;
    cycle();
    checks++;
    if ({cyc_rspv, cyc_busy, cyc_start, cyc_alu, cyc_data, cyc_err, err_cnt} !== '0) begin
      errors++;
      $display("FAIL rw_outputs: rsp_valid=%b busy=%b alu=%h data=%h err_cnt=%0d expected 0",
               cyc_rspv, cyc_busy, cyc_alu, cyc_data, err_cnt);
    end
    man_res  = 16'h1234;
    man_done = 1'b1;
    cycle();
    man_done = 1'b0;
    noisy = (cyc_rspv != '0) || cyc_busy;
    repeat (4) begin
      cycle();
      if (cyc_rspv != '0 || cyc_busy) noisy = 1'b1;
    end
    checks++;
    if (noisy) begin
      errors++;
      $display("FAIL rw_no_resp: activity after reset got 1 expected 0");
    end
    alu_auto = 1'b1;
    drive_req(3, 8'h44, 8'h02, 3'd0);
    drive_req(0, 8'h66, 8'h99, 3'd7);
    sb.push_back(mk_exp(0, alu_fn(8'h66, 8'h99, 3'd7), 1'b0));
    sb.push_back(mk_exp(3, alu_fn(8'h44, 8'h02, 3'd0), 1'b0));
    first_g = 3'd7;
    got = 0;
    for (int c = 0; c < 40 && got < 2; c++) begin
      cycle();
      if (cyc_acc != '0 && first_g == 3'd7) first_g = idx_of(cyc_acc);
      if (cyc_rsp != '0) begin
        got++;
        checks++;
        e = sb.pop_front();
        if (cyc_rsp !== oh(e.idx) || cyc_data !== e.data || cyc_err !== e.err) begin
          errors++;
          $display("FAIL rw_resp%0d: rsp=%b data=%h err=%b expected %b %h %b",
                   got, cyc_rsp, cyc_data, cyc_err, oh(e.idx), e.data, e.err);
        end
      end
    end
    checks++;
    if (first_g !== 3'd0 || got != 2) begin
      errors++;
      $display("FAIL rw_priority: first grant=%0d responses=%0d expected 0 and 2",
               first_g, got);
    end
  endtask

  initial begin
    reset     = 1'b1;
    rq_valid  = '0;
    rq_a      = '0;
    rq_b      = '0;
    rq_op     = '0;
    rsp_ready = '1;
    man_done  = 1'b0;
    man_res   = '0;
    alu_auto  = 1'b1;
    alu_delay = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_backpressure();
    test_timeout_boundary();
    test_reset_in_wait();
    checks++;
    if (sb.size() != 0 || viol != 0) begin
      errors++;
      $display("FAIL final: leftover expectations=%0d ready violations=%0d expected 0 and 0",
               sb.size(), viol);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop in case a wait loop never terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
